key_frame_loader: RTL and testbench
===================================

KEY_FRAME_LOADER -- requirements
Module: key_frame_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of the input stream and plaintext path.
REQ-002 Parameter KEY_WIDTH, default 4*DATA_WIDTH+2 (34), width of the assembled key.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 byte_in  input  DATA_WIDTH  inbound frame byte.
REQ-006 byte_valid  input  1  byte_in holds a valid byte.
REQ-007 byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 key  output  KEY_WIDTH  assembled key for the parameter extractor.
REQ-009 key_valid_out  output  1  one-cycle pulse: key is new.
REQ-010 plaintext_out  output  DATA_WIDTH  plaintext byte.
REQ-011 plaintext_valid_out  output  1  one-cycle pulse per plaintext byte.
REQ-012 busy  output  1  high whenever the FSM is outside IDLE.
REQ-013 frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-014 Frame format: header 0xA5, PREC byte, K0, K1, K2, K3, LEN byte, then LEN plaintext bytes (LEN 0..255).
REQ-015 A byte is accepted only in a cycle where byte_valid and byte_ready are both 1; other cycles leave state unchanged.
REQ-016 FSM states: IDLE, PREC, KEY, ISSUE, LEN, DATA.
REQ-017 IDLE: accepted 0xA5 -> PREC; any other accepted byte -> stay IDLE and pulse frame_err next cycle.
REQ-018 PREC: accepted byte with bits[7:2] nonzero -> IDLE, frame_err pulse, key unchanged; otherwise store bits[1:0] -> KEY.
REQ-019 KEY: 2-bit byte counter; K0 goes to key[7:0], K1 to [15:8], K2 to [23:16], K3 to [31:24]; PREC bits go to key[33:32]; after K3 -> ISSUE.
REQ-020 Key bytes are staged in a shadow register; the key output updates only on entry to ISSUE, so key stays stable between key_valid_out pulses and through aborted frames.
REQ-021 ISSUE: lasts exactly one cycle; key_valid_out = 1 and byte_ready = 0; then -> LEN.
REQ-022 key_valid_out asserts in the cycle after K3 is accepted (latency 1).
REQ-023 LEN: store the accepted byte in the remaining counter; LEN = 0 -> IDLE, otherwise -> DATA.
REQ-024 DATA: each accepted byte is registered onto plaintext_out with plaintext_valid_out = 1 the next cycle; the counter decrements; at 1 -> IDLE after that byte.
REQ-025 byte_ready = 1 in every state except ISSUE.
REQ-026 plaintext_out holds its last value when plaintext_valid_out is 0.
REQ-027 Back-to-back frames are supported: a header may be accepted in the cycle after the last DATA or LEN=0 byte, with no idle gap.

Reset
REQ-028 rst_n low forces IDLE and clears the counters and shadow register immediately.
REQ-029 rst_n low forces these output values: key = 0, plaintext_out = 0, key_valid_out = 0, plaintext_valid_out = 0, frame_err = 0, busy = 0.
REQ-030 Reset mid-frame discards the partial frame; the next valid frame must start with a header.

Structure
REQ-031 A shared package holds the FSM state encoding, HDR_BYTE = 8'hA5, and KEY_WIDTH.
REQ-032 The implementation is a single module with no sub-modules; FSM, counters and output registers are in one clocked process.

Verification
REQ-033 Frame A5,02,11,22,33,44,03,AA,BB,CC -> key_valid_out pulses once with key = 34'h2_4433_2211; plaintext_valid_out pulses 3 times with AA, BB, CC; busy returns to 0.
REQ-034 Frame A5,01,...,LEN=00 immediately followed by a second frame -> two key_valid_out pulses, zero plaintext pulses, no dropped header.
REQ-035 Leading byte 5A, then a valid frame -> one frame_err pulse, then a normal decode of the frame.
REQ-036 PREC byte 0x04 -> frame_err pulse, return to IDLE, key retains its previous value, no key_valid_out.
REQ-037 byte_valid held high continuously across ISSUE -> byte_ready is 0 for exactly that one cycle and the LEN byte is accepted the cycle after.
REQ-038 rst_n asserted after K2 -> all outputs are 0; a following complete frame decodes correctly.

Source files
------------

// File: rtl/key_frame_loader_pkg.sv
// Shared definitions for the key frame loader: FSM encoding, header byte, key width.
package key_frame_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREC  = 3'd1,
        ST_KEY   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_LEN   = 3'd4,
        ST_DATA  = 3'd5
    } state_t;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam int         KEY_WIDTH = 34;

endpackage : key_frame_loader_pkg

// File: rtl/key_frame_loader.sv
// Parses framed byte streams: header, precision byte, four key bytes, length,
// then plaintext. Issues the assembled key as a one-cycle pulse and forwards
// plaintext bytes one per accepted input byte.
//
// Handshake: a byte transfers on a rising clk edge only when byte_valid and
// byte_ready are both 1 in that cycle; byte_ready depends on state alone and
// drops for the single ISSUE cycle. key_valid_out, plaintext_valid_out and
// frame_err are one-cycle pulses with no back-pressure.
module key_frame_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int KEY_WIDTH  = 4*DATA_WIDTH+2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [KEY_WIDTH-1:0]  key,
    output logic                  key_valid_out,
    output logic [DATA_WIDTH-1:0] plaintext_out,
    output logic                  plaintext_valid_out,
    output logic                  busy,
    output logic                  frame_err,
    output logic [2:0]            dbg_state
);

    import key_frame_loader_pkg::*;

    state_t                  state;
    state_t                  next_state;
    logic                    accept;
    logic                    hdr_ok;
    logic                    prec_ok;
    logic [1:0]              key_cnt;
    logic [1:0]              prec_q;
    logic [3*DATA_WIDTH-1:0] key_shadow;
    logic [DATA_WIDTH-1:0]   remain;

    // Handshake decode and next-state selection.
    always_comb begin
        byte_ready = (state != ST_ISSUE);
        accept     = byte_valid && byte_ready;
        hdr_ok     = (byte_in == DATA_WIDTH'(HDR_BYTE));
        prec_ok    = (byte_in[DATA_WIDTH-1:2] == '0);
        busy       = (state != ST_IDLE);
        dbg_state  = state;
        next_state = state;
        case (state)
            ST_IDLE:  if (accept && hdr_ok) next_state = ST_PREC;
            ST_PREC:  if (accept) next_state = prec_ok ? ST_KEY : ST_IDLE;
            ST_KEY:   if (accept && key_cnt == 2'd3) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_LEN;
            ST_LEN:   if (accept) next_state = (byte_in == '0) ? ST_IDLE : ST_DATA;
            ST_DATA:  if (accept && remain == DATA_WIDTH'(1)) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State, counters, key shadow and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            key_cnt             <= '0;
            prec_q              <= '0;
            key_shadow          <= '0;
            remain              <= '0;
            key                 <= '0;
            key_valid_out       <= 1'b0;
            plaintext_out       <= '0;
            plaintext_valid_out <= 1'b0;
            frame_err           <= 1'b0;
        end else begin
            state               <= next_state;
            key_valid_out       <= 1'b0;
            plaintext_valid_out <= 1'b0;
            frame_err           <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (!hdr_ok) frame_err <= 1'b1;
                    end
                    ST_PREC: begin
                        if (!prec_ok) begin
                            frame_err <= 1'b1;
                        end else begin
                            prec_q  <= byte_in[1:0];
                            key_cnt <= '0;
                        end
                    end
                    ST_KEY: begin
                        key_cnt <= key_cnt + 2'd1;
                        case (key_cnt)
                            2'd0: key_shadow[DATA_WIDTH-1:0]              <= byte_in;
                            2'd1: key_shadow[2*DATA_WIDTH-1:DATA_WIDTH]   <= byte_in;
                            2'd2: key_shadow[3*DATA_WIDTH-1:2*DATA_WIDTH] <= byte_in;
                            default: begin
                                // K3 arrives: publish the whole key as we enter ISSUE.
                                key           <= KEY_WIDTH'({prec_q, byte_in, key_shadow});
                                key_valid_out <= 1'b1;
                            end
                        endcase
                    end
                    ST_LEN: begin
                        remain <= byte_in;
                    end
                    ST_DATA: begin
                        plaintext_out       <= byte_in;
                        plaintext_valid_out <= 1'b1;
                        remain              <= remain - DATA_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : key_frame_loader

// File: tb/tb_key_frame_loader.sv
// Bench for key_frame_loader: directed frames plus randomized streams checked
// against a byte-stream parser model.
module tb_key_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [33:0] key;
    logic        key_valid_out;
    logic [7:0]  plaintext_out;
    logic        plaintext_valid_out;
    logic        busy;
    logic        frame_err;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [33:0] exp_key_q[$];
    logic [33:0] obs_key_q[$];
    logic [7:0]  exp_pt_q[$];
    logic [7:0]  obs_pt_q[$];
    int          exp_err;
    int          obs_err;
    logic [33:0] model_key = '0;

    // clock / reset
    always #5 clk = ~clk;

    key_frame_loader dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .byte_in             (byte_in),
        .byte_valid          (byte_valid),
        .byte_ready          (byte_ready),
        .key                 (key),
        .key_valid_out       (key_valid_out),
        .plaintext_out       (plaintext_out),
        .plaintext_valid_out (plaintext_valid_out),
        .busy                (busy),
        .frame_err           (frame_err),
        .dbg_state           (dbg_state)
    );

    // monitor: collect output pulses away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid_out)       obs_key_q.push_back(key);
            if (plaintext_valid_out) obs_pt_q.push_back(plaintext_out);
            if (frame_err)           obs_err++;
        end
    end

    task automatic clear_scoreboard();
        exp_key_q.delete(); obs_key_q.delete();
        exp_pt_q.delete();  obs_pt_q.delete();
        exp_err = 0; obs_err = 0;
    endtask

    // reference model: parse a whole byte stream frame by frame
    task automatic model_stream(input logic [7:0] s[$]);
        int i = 0;
        int n = s.size();
        logic [7:0] p;
        int len;
        while (i < n) begin
            if (s[i] != 8'hA5) begin exp_err++; i++; continue; end
            i++;
            if (i >= n) break;
            p = s[i]; i++;
            if (p[7:2] != 6'd0) begin exp_err++; continue; end
            if (i + 4 > n) break;
            model_key = {p[1:0], s[i+3], s[i+2], s[i+1], s[i]};
            exp_key_q.push_back(model_key);
            i += 4;
            if (i >= n) break;
            len = int'(s[i]); i++;
            for (int j = 0; j < len && i < n; j++) begin
                exp_pt_q.push_back(s[i]); i++;
            end
        end
    endtask

    // driver: present one byte and hold it until it is accepted
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            n_checks++;
            $display("FAIL send_byte_timeout: byte_ready got 0 after %0d cycles, need 1", waited);
        end
        @(posedge clk);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        foreach (s[k]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(negedge clk);
                    byte_valid = 1'b0;
                end
            end
            send_byte(s[k]);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        byte_valid = 1'b0;
        #2;
        n_checks++; if (key !== 34'h0) $display("FAIL reset_key: got %h need 0", key); else n_pass++;
        n_checks++; if (key_valid_out !== 1'b0) $display("FAIL reset_kv: got %b need 0", key_valid_out); else n_pass++;
        n_checks++; if (plaintext_out !== 8'h0) $display("FAIL reset_pt: got %h need 0", plaintext_out); else n_pass++;
        n_checks++; if (plaintext_valid_out !== 1'b0) $display("FAIL reset_pv: got %b need 0", plaintext_valid_out); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b need 0", frame_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else n_pass++;
        n_checks++; if (byte_ready !== 1'b1) $display("FAIL reset_ready: got %b need 1", byte_ready); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] s[$];
        clear_scoreboard();
        s = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        model_stream(s);
        send_stream(s, 1'b0);
        n_checks++; if (obs_key_q.size() != 1) $display("FAIL basic_key_count: got %0d need 1", obs_key_q.size()); else n_pass++;
        if (obs_key_q.size() > 0) begin
            n_checks++; if (obs_key_q[0] !== 34'h2_4433_2211) $display("FAIL basic_key: got %h need 244332211", obs_key_q[0]); else n_pass++;
        end
        n_checks++; if (obs_pt_q.size() != exp_pt_q.size()) $display("FAIL basic_pt_count: got %0d need %0d", obs_pt_q.size(), exp_pt_q.size()); else n_pass++;
        for (int i = 0; i < exp_pt_q.size() && i < obs_pt_q.size(); i++) begin
            n_checks++; if (obs_pt_q[i] !== exp_pt_q[i]) $display("FAIL basic_pt[%0d]: got %h need %h", i, obs_pt_q[i], exp_pt_q[i]); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b need 0", busy); else n_pass++;
        n_checks++; if (plaintext_out !== 8'hCC) $display("FAIL basic_pt_hold: got %h need cc", plaintext_out); else n_pass++;
        n_checks++; if (obs_err != 0) $display("FAIL basic_err: got %0d need 0", obs_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        clear_scoreboard();
        s = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00,
              8'hA5, 8'h03, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        model_stream(s);
        send_stream(s, 1'b0);
        n_checks++; if (obs_key_q.size() != 2) $display("FAIL b2b_key_count: got %0d need 2", obs_key_q.size()); else n_pass++;
        for (int i = 0; i < exp_key_q.size() && i < obs_key_q.size(); i++) begin
            n_checks++; if (obs_key_q[i] !== exp_key_q[i]) $display("FAIL b2b_key[%0d]: got %h need %h", i, obs_key_q[i], exp_key_q[i]); else n_pass++;
        end
        n_checks++; if (obs_pt_q.size() != 0) $display("FAIL b2b_pt_count: got %0d need 0", obs_pt_q.size()); else n_pass++;
        n_checks++; if (obs_err != 0) $display("FAIL b2b_err: got %0d need 0", obs_err); else n_pass++;
    endtask

    task automatic test_bad_header();
        logic [7:0] s[$];
        clear_scoreboard();
        s = '{8'h5A, 8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'hDE, 8'hAD};
        model_stream(s);
        send_stream(s, 1'b0);
        n_checks++; if (obs_err != exp_err) $display("FAIL badhdr_err: got %0d need %0d", obs_err, exp_err); else n_pass++;
        n_checks++; if (obs_key_q.size() != exp_key_q.size()) $display("FAIL badhdr_key_count: got %0d need %0d", obs_key_q.size(), exp_key_q.size()); else n_pass++;
        for (int i = 0; i < exp_key_q.size() && i < obs_key_q.size(); i++) begin
            n_checks++; if (obs_key_q[i] !== exp_key_q[i]) $display("FAIL badhdr_key[%0d]: got %h need %h", i, obs_key_q[i], exp_key_q[i]); else n_pass++;
        end
        n_checks++; if (obs_pt_q.size() != exp_pt_q.size()) $display("FAIL badhdr_pt_count: got %0d need %0d", obs_pt_q.size(), exp_pt_q.size()); else n_pass++;
        for (int i = 0; i < exp_pt_q.size() && i < obs_pt_q.size(); i++) begin
            n_checks++; if (obs_pt_q[i] !== exp_pt_q[i]) $display("FAIL badhdr_pt[%0d]: got %h need %h", i, obs_pt_q[i], exp_pt_q[i]); else n_pass++;
        end
    endtask

    task automatic test_bad_prec();
        logic [7:0] s[$];
        clear_scoreboard();
        s = '{8'hA5, 8'h04};
        model_stream(s);
        send_stream(s, 1'b0);
        n_checks++; if (obs_err != 1) $display("FAIL badprec_err: got %0d need 1", obs_err); else n_pass++;
        n_checks++; if (obs_key_q.size() != 0) $display("FAIL badprec_kv: got %0d pulses need 0", obs_key_q.size()); else n_pass++;
        n_checks++; if (key !== model_key) $display("FAIL badprec_key_hold: got %h need %h", key, model_key); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL badprec_busy: got %b need 0", busy); else n_pass++;
    endtask

    task automatic test_issue_stall();
        logic [7:0] s[$];
        clear_scoreboard();
        s = '{8'hA5, 8'h01, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02, 8'h5C, 8'h3E};
        model_stream(s);
        for (int i = 0; i < 6; i++) send_byte(s[i]);
        // ISSUE cycle: LEN is already presented and must be held off
        @(negedge clk);
        byte_in = s[6];
        n_checks++; if (byte_ready !== 1'b0) $display("FAIL stall_ready_issue: got %b need 0", byte_ready); else n_pass++;
        n_checks++; if (key_valid_out !== 1'b1) $display("FAIL stall_kv: got %b need 1", key_valid_out); else n_pass++;
        n_checks++; if (key !== model_key) $display("FAIL stall_key: got %h need %h", key, model_key); else n_pass++;
        @(negedge clk);
        n_checks++; if (byte_ready !== 1'b1) $display("FAIL stall_ready_after: got %b need 1", byte_ready); else n_pass++;
        n_checks++; if (key_valid_out !== 1'b0) $display("FAIL stall_kv_once: got %b need 0", key_valid_out); else n_pass++;
        @(posedge clk);
        send_byte(s[7]);
        send_byte(s[8]);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (obs_pt_q.size() != 2) $display("FAIL stall_pt_count: got %0d need 2", obs_pt_q.size()); else n_pass++;
        for (int i = 0; i < exp_pt_q.size() && i < obs_pt_q.size(); i++) begin
            n_checks++; if (obs_pt_q[i] !== exp_pt_q[i]) $display("FAIL stall_pt[%0d]: got %h need %h", i, obs_pt_q[i], exp_pt_q[i]); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL stall_busy: got %b need 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] s[$];
        clear_scoreboard();
        s = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03};
        foreach (s[k]) send_byte(s[k]);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        model_key = '0;
        #1;
        n_checks++; if (key !== 34'h0) $display("FAIL midrst_key: got %h need 0", key); else n_pass++;
        n_checks++; if (plaintext_out !== 8'h0) $display("FAIL midrst_pt: got %h need 0", plaintext_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b need 0", busy); else n_pass++;
        n_checks++; if ({key_valid_out, plaintext_valid_out, frame_err} !== 3'b000) $display("FAIL midrst_pulses: got %b need 000", {key_valid_out, plaintext_valid_out, frame_err}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s = '{8'hA5, 8'h03, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h01, 8'h77};
        model_stream(s);
        send_stream(s, 1'b0);
        n_checks++; if (obs_key_q.size() != 1) $display("FAIL midrst_key_count: got %0d need 1", obs_key_q.size()); else n_pass++;
        if (obs_key_q.size() > 0) begin
            n_checks++; if (obs_key_q[0] !== exp_key_q[0]) $display("FAIL midrst_newkey: got %h need %h", obs_key_q[0], exp_key_q[0]); else n_pass++;
        end
        n_checks++; if (obs_pt_q.size() != 1) $display("FAIL midrst_pt_count: got %0d need 1", obs_pt_q.size()); else n_pass++;
        if (obs_pt_q.size() > 0) begin
            n_checks++; if (obs_pt_q[0] !== 8'h77) $display("FAIL midrst_ptval: got %h need 77", obs_pt_q[0]); else n_pass++;
        end
        n_checks++; if (obs_err != 0) $display("FAIL midrst_err: got %0d need 0", obs_err); else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [7:0] s[$];
        logic [7:0] b;
        int len;
        clear_scoreboard();
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                s.push_back(b);
            end
            s.push_back(8'hA5);
            if ($urandom_range(0, 5) == 0) begin
                s.push_back({6'($urandom_range(1, 63)), 2'($urandom_range(0, 3))});
                continue;
            end
            s.push_back({6'd0, 2'($urandom_range(0, 3))});
            repeat (4) s.push_back(8'($urandom_range(0, 255)));
            len = $urandom_range(0, 5);
            s.push_back(8'(len));
            repeat (len) s.push_back(8'($urandom_range(0, 255)));
        end
        model_stream(s);
        send_stream(s, 1'b1);
        n_checks++; if (obs_err != exp_err) $display("FAIL rand_err: got %0d need %0d", obs_err, exp_err); else n_pass++;
        n_checks++; if (obs_key_q.size() != exp_key_q.size()) $display("FAIL rand_key_count: got %0d need %0d", obs_key_q.size(), exp_key_q.size()); else n_pass++;
        for (int i = 0; i < exp_key_q.size() && i < obs_key_q.size(); i++) begin
            n_checks++; if (obs_key_q[i] !== exp_key_q[i]) $display("FAIL rand_key[%0d]: got %h need %h", i, obs_key_q[i], exp_key_q[i]); else n_pass++;
        end
        n_checks++; if (obs_pt_q.size() != exp_pt_q.size()) $display("FAIL rand_pt_count: got %0d need %0d", obs_pt_q.size(), exp_pt_q.size()); else n_pass++;
        for (int i = 0; i < exp_pt_q.size() && i < obs_pt_q.size(); i++) begin
            n_checks++; if (obs_pt_q[i] !== exp_pt_q[i]) $display("FAIL rand_pt[%0d]: got %h need %h", i, obs_pt_q[i], exp_pt_q[i]); else n_pass++;
        end
        n_checks++; if (key !== model_key) $display("FAIL rand_final_key: got %h need %h", key, model_key); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_bad_header();
        test_bad_prec();
        test_issue_stall();
        test_reset_mid_frame();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_key_frame_loader
